// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: ALU operation encodings (mirroring the shared core defines) and decode helpers
package seq_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    function automatic logic is_shift(input logic [3:0] t);
        return (t == ALU_SLL) || (t == ALU_SRL) || (t == ALU_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_onecycle.sv
// alu_onecycle: combinational single-cycle ops; shifts pass op1 through for the zero-amount case
module alu_onecycle
    import seq_alu_pkg::*;
(
    input  logic [3:0]  alu_type,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res
);

    always_comb begin
        res = (alu_type == ALU_ADD)  ? op1 + op2 :
              (alu_type == ALU_SUB)  ? op1 - op2 :
              (alu_type == ALU_SLT)  ? {31'b0, $signed(op1) < $signed(op2)} :
              (alu_type == ALU_SLTU) ? {31'b0, op1 < op2} :
              (alu_type == ALU_XOR)  ? op1 ^ op2 :
              (alu_type == ALU_OR)   ? op1 | op2 :
              (alu_type == ALU_AND)  ? op1 & op2 :
              is_shift(alu_type)     ? op1 : 32'b0;
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes and an iterative SHIFT_STEP-bit shifter
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_type,
    input  logic [31:0] alu_op1,
    input  logic [31:0] alu_op2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_res,
    output logic        zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 ||
          SHIFT_STEP == 8 || SHIFT_STEP == 16 || SHIFT_STEP == 32)) begin : g_bad_step
        $error("SHIFT_STEP must be a power of two between 1 and 32");
    end

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t      state, state_nxt;
    logic [31:0] work, shifted, one_res;
    logic [5:0]  cnt, step;
    logic [3:0]  sh_type;
    logic        accept, start_shift, last;

    alu_onecycle u_one (
        .alu_type(alu_type),
        .op1     (alu_op1),
        .op2     (alu_op2),
        .res     (one_res)
    );

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign start_shift = is_shift(alu_type) && (alu_op2[4:0] != 5'd0);
    assign step        = (cnt < STEP) ? cnt : STEP;
    assign last        = (cnt == step);

    // step never reaches 32 because the count starts at most at 31
    always_comb begin
        shifted = (sh_type == ALU_SLL) ? work << step :
                  (sh_type == ALU_SRA) ? 32'($signed(work) >>> step) : work >> step;
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = IDLE;
        else if (accept)
            state_nxt = start_shift ? SHIFT : DONE;
        else if (state == SHIFT && last)
            state_nxt = DONE;
        else if (state == DONE && out_ready)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_res <= '0;
            zero    <= 1'b0;
            work    <= '0;
            cnt     <= '0;
            sh_type <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            if (start_shift) begin
                work    <= alu_op1;
                cnt     <= {1'b0, alu_op2[4:0]};
                sh_type <= alu_type;
            end else begin
                alu_res <= one_res;
                zero    <= (one_res == 32'b0);
            end
        end else if (state == SHIFT) begin
            work <= shifted;
            cnt  <= cnt - step;
            if (last) begin
                alu_res <= shifted;
                zero    <= (shifted == 32'b0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus hand-written handshake, flush and reset sequences
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic [3:0]  alu_type = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        in_ready1, out_valid1, zero1, in_ready4, out_valid4, zero4;
    logic [31:0] res1, res4;
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    seq_alu #(.SHIFT_STEP(1)) u1 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .alu_type(alu_type), .alu_op1(op1), .alu_op2(op2), .out_valid(out_valid1),
        .out_ready(out_ready), .alu_res(res1), .zero(zero1)
    );

    seq_alu #(.SHIFT_STEP(4)) u4 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
        .alu_type(alu_type), .alu_op1(op1), .alu_op2(op2), .out_valid(out_valid4),
        .out_ready(out_ready), .alu_res(res4), .zero(zero4)
    );

    typedef struct {
        logic        sel4;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int   lat = 0;
        logic busy_bad = 1'b0;
        @(negedge clk);
        alu_type = v.op;
        op1 = v.a;
        op2 = v.b;
        if (v.sel4) in_valid4 = 1'b1; else in_valid = 1'b1;
        check($sformatf("v%0d_ready", idx), v.sel4 ? in_ready4 : in_ready1, 1);
        do begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_valid4 = 1'b0;
            alu_type  = ALU_AND;
            op1       = ~v.a;
            op2       = v.b ^ 32'h0000_0013;
            lat++;
            if (!(v.sel4 ? out_valid4 : out_valid1) && (v.sel4 ? in_ready4 : in_ready1))
                busy_bad = 1'b1;
        end while (!(v.sel4 ? out_valid4 : out_valid1) && lat < 100);
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_res", idx), v.sel4 ? res4 : res1, v.res);
        check($sformatf("v%0d_zero", idx), v.sel4 ? zero4 : zero1, v.z);
        check($sformatf("v%0d_busy_ready", idx), busy_bad, 0);
        check($sformatf("v%0d_done_ready", idx), v.sel4 ? in_ready4 : in_ready1, 0);
        @(negedge clk);
        check($sformatf("v%0d_valid_drop", idx), v.sel4 ? out_valid4 : out_valid1, 0);
        check($sformatf("v%0d_idle_ready", idx), v.sel4 ? in_ready4 : in_ready1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic saw;
        vecs[0]  = '{1'b0, ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1};
        vecs[1]  = '{1'b0, ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1};
        vecs[2]  = '{1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
        vecs[3]  = '{1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
        vecs[4]  = '{1'b0, ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1};
        vecs[5]  = '{1'b0, ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1};
        vecs[6]  = '{1'b0, ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[7]  = '{1'b0, ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[8]  = '{1'b0, 4'b1111,  32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b1, 1};
        vecs[9]  = '{1'b0, ALU_SLL,  32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1};
        vecs[10] = '{1'b0, ALU_SLL,  32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0, 5};
        vecs[11] = '{1'b0, ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 32};
        vecs[12] = '{1'b0, ALU_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32};
        vecs[13] = '{1'b0, ALU_SRA,  32'h4000_0000, 32'h0000_0003, 32'h0800_0000, 1'b0, 4};
        vecs[14] = '{1'b1, ALU_SRL,  32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, 2};
        vecs[15] = '{1'b1, ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 9};

        #1;
        check("rst_res", res1, 0);
        check("rst_zero", zero1, 0);
        check("rst_valid", out_valid1, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready1, 1);

        for (int i = 0; i < 16; i++) run_op(i, vecs[i]);

        // back-pressure: result held, next request waits for the output handshake
        @(negedge clk);
        out_ready = 1'b0;
        alu_type = ALU_ADD; op1 = 32'd1; op2 = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        alu_type = ALU_XOR; op1 = 32'd3; op2 = 32'd5;
        check("bp_valid_rise", out_valid1, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold_res%0d", k), res1, 32'd3);
            check($sformatf("bp_hold_valid%0d", k), out_valid1, 1);
            check($sformatf("bp_hold_ready%0d", k), in_ready1, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", in_ready1, 1);
        check("bp_idle_valid", out_valid1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_valid", out_valid1, 1);
        check("bp_next_res", res1, 32'd6);
        @(negedge clk);
        check("bp_next_drop", out_valid1, 0);

        // flush beats a same-cycle accept
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; alu_type = ALU_ADD; op1 = 32'd1; op2 = 32'd1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fa_ready", in_ready1, 1);
        check("fa_valid", out_valid1, 0);
        @(negedge clk);
        check("fa_valid_later", out_valid1, 0);

        // flush in the third cycle of a 20-bit shift
        @(negedge clk);
        alu_type = ALU_SLL; op1 = 32'd1; op2 = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_ready", in_ready1, 1);
        check("fl_valid", out_valid1, 0);
        saw = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid1) saw = 1'b1;
        end
        check("fl_no_pulse", saw, 0);
        check("fl_res_kept", res1, 32'd6);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        alu_type = ALU_SRA; op1 = 32'h8000_0000; op2 = 32'd31; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("ar_busy", in_ready1, 0);
        #2 rstn = 1'b0;
        #1;
        check("ar_res", res1, 0);
        check("ar_zero", zero1, 0);
        check("ar_valid", out_valid1, 0);
        check("ar_ready", in_ready1, 1);
        @(negedge clk);
        rstn = 1'b1;
        run_op(16, '{1'b0, ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execution unit that consumes the decoded ALU request: 4-bit alu_type plus two 32-bit operands.
- Sits downstream of instruction decode / ALU control in the lab2 core and replaces the single-cycle ALU for the multi-cycle datapath.
- Logic, compare and add/sub ops: one cycle. Shifts: iterative, SHIFT_STEP bits per cycle.
- Valid/ready handshake on both input and output, so the control FSM can stall on it.

Parameters:
- SHIFT_STEP, 1, bits shifted per cycle in SHIFT state; legal values 1, 2, 4, 8, 16, 32 (power of two only).

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns to IDLE and drops any in-flight op
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- alu_type  input  4  operation, encoded with the shared `ADD/`SUB/`SLL/`SLT/`SLTU/`XOR/`SRL/`SRA/`OR/`AND macros
- alu_op1  input  32  operand 1, or shift source
- alu_op2  input  32  operand 2; bits [4:0] are the shift amount
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- alu_res  output  32  result, registered
- zero  output  1  registered, equals (alu_res == 0)

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, alu_res=0, zero=0, out_valid=0, shift counter=0. in_ready=1 once reset releases.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded directly from state.
- Accept happens when in_valid && in_ready. Operands and alu_type are latched on accept; input changes after accept are ignored.

IDLE on accept:
- Non-shift op: result is computed combinationally and registered; next state DONE. out_valid rises 1 cycle after accept.
- Shift op with shamt==0: alu_res=op1; next state DONE (latency 1).
- Shift op with shamt!=0: working reg=op1, cnt=shamt; next state SHIFT.

SHIFT, each cycle:
- step = min(SHIFT_STEP, cnt). Shift the working reg by step: SLL fills zeros, SRL fills zeros, SRA fills with bit31.
- cnt -= step. When cnt reaches 0, register the result and go to DONE.
- Latency from accept to out_valid = ceil(shamt/SHIFT_STEP)+1.

DONE:
- Hold alu_res and zero stable until out_ready. Then go to IDLE the next cycle.
- No new accept is possible in the DONE cycle, so throughput is at most 1 op per 2 cycles.

Arithmetic:
- ADD and SUB wrap modulo 2^32; no overflow flag.
- SLT is a signed compare; SLTU is unsigned. Both produce 32'd0 or 32'd1.
- Unused alu_type encodings produce alu_res=0 with latency 1. Never X.

Flush and reset mid-operation:
- flush high in any state: next state IDLE, out_valid=0, cnt=0. alu_res keeps its old value.
- flush wins over a same-cycle accept or out_ready.
- rstn falling mid-SHIFT immediately forces the reset values.

Other boundaries:
- out_ready held high before DONE has no effect.
- in_valid held high during SHIFT/DONE is not accepted; the request stays pending until IDLE.

Decomposition:
- Operation encodings stay in the shared src/defines.v macros. No new encodings are introduced.
- State encoding and the SHIFT_STEP legality check live local to seq_alu.
- One sub-module: alu_onecycle, the purely combinational ADD/SUB/SLT/SLTU/XOR/OR/AND/zero-shift path. seq_alu owns the FSM, shift iterator and output registers.

Test Plan:
- ADD, op1=32'h7FFF_FFFF, op2=1, out_ready=1 -> out_valid 1 cycle after accept, alu_res=32'h8000_0000, zero=0, back to IDLE the next cycle.
- SUB, op1=5, op2=5 -> alu_res=0, zero=1. SLT with op1=32'hFFFF_FFFF, op2=1 -> 1. SLTU with the same operands -> 0.
- SRA, op1=32'h8000_0000, op2=31, SHIFT_STEP=1 -> out_valid 32 cycles after accept, alu_res=32'hFFFF_FFFF, in_ready=0 throughout.
- SLL, op1=1, op2=32'h0000_0020 (shamt=0) -> latency 1, alu_res=1. SRL, op1=32'hF000_0000, op2=4 with SHIFT_STEP=4 -> latency 2, alu_res=32'h0F00_0000.
- Back-pressure: out_ready=0 for 5 cycles after DONE -> alu_res/out_valid held stable, in_ready stays 0, a pending in_valid is accepted only after the out handshake.
- Flush at cycle 3 of a 20-bit SLL -> IDLE next cycle, no out_valid pulse. Then an async rstn pulse mid-SHIFT -> outputs at reset values immediately, and the next request completes correctly.
